// File: rtl/deser16.sv
// deser16: serial-to-parallel receiver for the 16-bit shift-register link.
// Bits are accepted one per qualified clock, MSB-first or LSB-first. They are
// assembled into WIDTH-bit words and handed to a consumer through a one-entry
// holding register with a valid/ready handshake. Words that complete while
// the holding register is still full are dropped and flagged as overrun.
module deser16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             left_right,
  input  logic             sync_clr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  // Receiver states: IDLE means no bits of the current word are held yet.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Count value at which the next accepted bit completes a word.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Registered state.
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sr_q,    sr_d;
  logic             dir_q,   dir_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;

  // Datapath helpers.
  logic             dir_eff;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_bit;
  logic             complete;
  logic             load_ok;
  logic             load;
  logic             drop;
  logic             consume;

  // Shift value and word-completion / handshake qualifiers for this edge.
  // The first bit of a word must already use the newly sampled direction,
  // so in IDLE the live left_right input selects the shift.
  always_comb begin
    dir_eff  = (state_q == IDLE) ? left_right : dir_q;
    shifted  = dir_eff ? {sr_q[WIDTH-2:0], serial_in}
                       : {serial_in, sr_q[WIDTH-1:1]};
    accept   = bit_valid && !sync_clr;
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    complete = accept && last_bit;
    load_ok  = !valid_q || out_ready;
    load     = complete && load_ok;
    drop     = complete && !load_ok;
    consume  = valid_q && out_ready;
  end

  // Bit assembly: shift register, bit counter, latched direction, state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    if (sync_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (bit_valid) begin
      sr_d = shifted;
      case (state_q)
        IDLE: begin
          dir_d   = left_right;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Holding register, valid flag and sticky overrun flag.
  // A load at the same edge as a consume keeps valid high; sync_clr only
  // touches overrun here, leaving the handshake side untouched.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      hold_d  = shifted;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
    if (sync_clr) begin
      ovr_d = 1'b0;
    end else if (drop) begin
      ovr_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Output drive.
  always_comb begin
    parallel_out = hold_q;
    out_valid    = valid_q;
    overrun      = ovr_q;
    bit_count    = cnt_q;
  end

endmodule

// File: tb/tb_deser16.sv
// Bench for deser16: directed scenarios plus randomized traffic, checked every
// cycle against a bit-list model of the receiver.
module tb_deser16;

  localparam int W = 16;

  logic          clk;
  logic          a_rst_n;
  logic          serial_in;
  logic          bit_valid;
  logic          left_right;
  logic          sync_clr;
  logic          out_ready;
  logic [W-1:0]  parallel_out;
  logic          out_valid;
  logic          overrun;
  logic [4:0]    bit_count;

  int checks;
  int failures;

  deser16 #(.WIDTH(16), .CW(5)) dut (
    .clk          (clk),
    .a_rst_n      (a_rst_n),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .left_right   (left_right),
    .sync_clr     (sync_clr),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .bit_count    (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: list of bits received for the current word, in arrival order.
  bit           m_bits[$];
  bit           m_dir;
  logic [W-1:0] m_hold;
  bit           m_valid;
  bit           m_ovr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dir   = 1'b0;
    m_hold  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Apply one rising edge's worth of behaviour using the inputs just seen.
  task automatic model_step();
    bit           cons;
    bit           loaded;
    logic [W-1:0] word;
    cons   = m_valid && out_ready;
    loaded = 1'b0;
    if (sync_clr) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (bit_valid) begin
      if (m_bits.size() == 0) m_dir = left_right;
      m_bits.push_back(serial_in);
      if (m_bits.size() == W) begin
        word = '0;
        for (int i = 0; i < W; i++) begin
          if (m_dir) word[W-1-i] = m_bits[i];
          else       word[i]     = m_bits[i];
        end
        m_bits.delete();
        if (!m_valid || out_ready) begin
          m_hold  = word;
          m_valid = 1'b1;
          loaded  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (cons && !loaded) m_valid = 1'b0;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_parallel_out", 32'(parallel_out), 32'(m_hold));
    check("cmp_out_valid",    32'(out_valid),    32'(m_valid));
    check("cmp_overrun",      32'(overrun),      32'(m_ovr));
    check("cmp_bit_count",    32'(bit_count),    32'(m_bits.size()));
  end

  // One clock: drive inputs, take the edge, advance the model.
  task automatic cycle(input logic sin, input logic bv, input logic lr,
                       input logic clr, input logic rdy);
    serial_in  = sin;
    bit_valid  = bv;
    left_right = lr;
    sync_clr   = clr;
    out_ready  = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic msb, input logic rdy_last);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = msb ? v[W-1-i] : v[i];
      cycle(b, 1'b1, msb, 1'b0, (i == W-1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic consume_one();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    a_rst_n    = 1'b0;
    serial_in  = 1'b0;
    bit_valid  = 1'b0;
    left_right = 1'b0;
    sync_clr   = 1'b0;
    out_ready  = 1'b0;
    #1;
    check("rst_parallel_out", 32'(parallel_out), 32'h0);
    check("rst_out_valid",    32'(out_valid),    32'h0);
    check("rst_overrun",      32'(overrun),      32'h0);
    check("rst_bit_count",    32'(bit_count),    32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    a_rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB-first word, no consumer.
    send_word(16'hA5C3, 1'b1, 1'b0);
    check("msb_word",     32'(parallel_out), 32'hA5C3);
    check("msb_valid",    32'(out_valid),    32'h1);
    check("msb_count",    32'(bit_count),    32'h0);
    check("msb_overrun",  32'(overrun),      32'h0);
    check("msb_model",    32'(m_hold),       32'hA5C3);
    consume_one();
    check("msb_consumed", 32'(out_valid),    32'h0);
    check("msb_keep",     32'(parallel_out), 32'hA5C3);

    // LSB-first with gaps and left_right toggling mid-word.
    begin
      logic [W-1:0] v;
      v = 16'h1234;
      for (int i = 0; i < W; i++) begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycle(v[i], 1'b1, (i == 0) ? 1'b0 : 1'(i % 2), 1'b0, 1'b0);
      end
    end
    check("lsb_word",  32'(parallel_out), 32'h1234);
    check("lsb_valid", 32'(out_valid),    32'h1);
    consume_one();

    // Back-pressure: second word dropped.
    send_word(16'h00FF, 1'b1, 1'b0);
    send_word(16'hFF00, 1'b1, 1'b0);
    check("bp_word",    32'(parallel_out), 32'h00FF);
    check("bp_overrun", 32'(overrun),      32'h1);
    consume_one();
    check("bp_consumed", 32'(out_valid), 32'h0);
    check("bp_sticky",   32'(overrun),   32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_cleared",  32'(overrun),   32'h0);

    // Completion and consume on the same edge.
    send_word(16'hBEEF, 1'b1, 1'b0);
    send_word(16'h1357, 1'b1, 1'b1);
    check("sim_word",    32'(parallel_out), 32'h1357);
    check("sim_valid",   32'(out_valid),    32'h1);
    check("sim_overrun", 32'(overrun),      32'h0);
    consume_one();

    // Asynchronous reset mid-word.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bit_count), 32'h7);
    #2;
    a_rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_count", 32'(bit_count),    32'h0);
    check("arst_word",  32'(parallel_out), 32'h0);
    check("arst_valid", 32'(out_valid),    32'h0);
    #4;
    a_rst_n = 1'b1;
    send_word(16'h8001, 1'b1, 1'b0);
    check("arst_next_word", 32'(parallel_out), 32'h8001);
    consume_one();

    // sync_clr mid-word beats an accepted bit.
    for (int i = 0; i < 9; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_count", 32'(bit_count), 32'h0);
    send_word(16'hC0DE, 1'b1, 1'b0);
    check("clr_next_word", 32'(parallel_out), 32'hC0DE);
    consume_one();

    // sync_clr on the completing edge: no load, no overrun.
    for (int i = 0; i < W-1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_last_valid", 32'(out_valid),    32'h0);
    check("clr_last_word",  32'(parallel_out), 32'hC0DE);
    check("clr_last_ovr",   32'(overrun),      32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) < 4));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
